// File: rtl/pong_ball_sequencer.sv
// -----------------------------------------------------------------------------
// pong_ball_sequencer
//
// Per-frame ball/game sequencer for the pong datapath. Once per video frame
// (rising edge of vblank) it waits SETTLE cycles for the collision detector's
// registered results, then performs one ball update: move, bounce off paddles
// and table edges, score and re-serve, and (optionally) ramp speed.
//
// Optional feature macro: PONG_SPEEDUP_EN
//   defined   : paddle hits are counted; every HITS_PER_STEP hits raise
//               ball_speed by one, saturating at SPEED_MAX.
//   undefined : no hit counter; ball_speed is the constant SPEED_INIT.
//
// Ports
//   clk          in   system clock (same domain as vblank)
//   rst          in   asynchronous, active-high reset
//   vblank       in   vertical blank level
//   start        in   one-cycle pulse, restarts the game from OVER
//   coll_wall    in   wall collision from the collision detector
//   coll_paddle  in   paddle collision from the collision detector
//   ball_h       out  ball column (11 bits)
//   ball_v       out  ball row (11 bits)
//   ball_dir     out  horizontal direction, `LEFT / `RIGHT
//   ball_vdir    out  vertical direction, 0 = up, 1 = down
//   ball_speed   out  pixels per frame on each axis (4 bits)
//   score_left   out  left player score (4 bits)
//   score_right  out  right player score (4 bits)
//   serving      out  high while the ball is parked before a serve
//   game_over    out  high once a player has reached WIN_SCORE
// -----------------------------------------------------------------------------

`ifndef LEFT
`define LEFT 1'b0
`endif
`ifndef RIGHT
`define RIGHT 1'b1
`endif

module pong_ball_sequencer #(
   parameter logic [10:0] H_CENTER      = 11'd316,
   parameter logic [10:0] V_CENTER      = 11'd236,
   parameter logic [10:0] TABLE_TOP     = 11'd8,
   parameter logic [10:0] TABLE_BOTTOM  = 11'd472,
   parameter logic [10:0] BALL_VSIZE    = 11'd8,
   parameter int unsigned SETTLE        = 3,
   parameter int unsigned SERVE_FRAMES  = 60,
   parameter logic [3:0]  SPEED_INIT    = 4'd2,
   parameter logic [3:0]  SPEED_MAX     = 4'd8,
   parameter int unsigned HITS_PER_STEP = 4,
   parameter logic [3:0]  WIN_SCORE     = 4'd9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblank,
   input  logic        start,
   input  logic        coll_wall,
   input  logic        coll_paddle,
   output logic [10:0] ball_h,
   output logic [10:0] ball_v,
   output logic        ball_dir,
   output logic        ball_vdir,
   output logic [3:0]  ball_speed,
   output logic [3:0]  score_left,
   output logic [3:0]  score_right,
   output logic        serving,
   output logic        game_over
);

   // SETTLE must cover the detector's vblank register plus a 2-flop margin,
   // so it is expected to be at least 2.
   localparam int unsigned SCW = $clog2(SERVE_FRAMES + 1);
   localparam int unsigned WCW = $clog2(SETTLE + 1);
   localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);
   localparam logic [WCW-1:0] SETTLE_W   = WCW'(SETTLE);
   localparam logic [10:0]    V_FLOOR    = TABLE_BOTTOM - BALL_VSIZE;

   typedef enum logic [2:0] {
      ST_SERVE = 3'd0,
      ST_PLAY  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EVAL  = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   state_t         state_q;
   logic           vblank_dly_q;
   logic [SCW-1:0] serve_cnt_q;
   logic [WCW-1:0] wait_cnt_q;
   logic [10:0]    ball_h_q;
   logic [10:0]    ball_v_q;
   logic           ball_dir_q;
   logic           ball_vdir_q;
   logic [3:0]     score_left_q;
   logic [3:0]     score_right_q;
   logic           serving_q;
   logic           game_over_q;

   logic           tick_s;
   logic [3:0]     speed_s;
   logic [10:0]    v_next_s;
   logic           vdir_next_s;
   logic [10:0]    h_next_s;
   logic [11:0]    v_ext_s;
   logic [11:0]    spd_ext_s;

`ifdef PONG_SPEEDUP_EN
   localparam logic [3:0] HIT_LAST = 4'(HITS_PER_STEP - 1);
   logic [3:0] hit_cnt_q;
   logic [3:0] ball_speed_q;
   assign speed_s = ball_speed_q;
`else
   assign speed_s = SPEED_INIT;
`endif

   assign tick_s    = vblank & ~vblank_dly_q;
   assign v_ext_s   = {1'b0, ball_v_q};
   assign spd_ext_s = {8'd0, speed_s};

   // Vertical step with edge clamping; compared in 12 bits so the sums cannot wrap.
   always_comb begin
      v_next_s    = ball_v_q;
      vdir_next_s = ball_vdir_q;
      if (ball_vdir_q == 1'b0) begin
         if (v_ext_s < ({1'b0, TABLE_TOP} + spd_ext_s)) begin
            v_next_s    = TABLE_TOP;
            vdir_next_s = 1'b1;
         end else begin
            v_next_s    = ball_v_q - {7'd0, speed_s};
            vdir_next_s = 1'b0;
         end
      end else begin
         if ((v_ext_s + {1'b0, BALL_VSIZE} + spd_ext_s) >= {1'b0, TABLE_BOTTOM}) begin
            v_next_s    = V_FLOOR;
            vdir_next_s = 1'b0;
         end else begin
            v_next_s    = ball_v_q + {7'd0, speed_s};
            vdir_next_s = 1'b1;
         end
      end
   end

   // Horizontal step when no collision is present.
   always_comb begin
      h_next_s = ball_h_q;
      if (ball_dir_q == `LEFT) begin
         h_next_s = ball_h_q - {7'd0, speed_s};
      end else begin
         h_next_s = ball_h_q + {7'd0, speed_s};
      end
   end

   // Game FSM: frame tick, settle wait, ball evaluation and scoring.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_SERVE;
         vblank_dly_q  <= 1'b0;
         serve_cnt_q   <= {SCW{1'b0}};
         wait_cnt_q    <= {WCW{1'b0}};
         ball_h_q      <= H_CENTER;
         ball_v_q      <= V_CENTER;
         ball_dir_q    <= `RIGHT;
         ball_vdir_q   <= 1'b1;
         score_left_q  <= 4'd0;
         score_right_q <= 4'd0;
         serving_q     <= 1'b1;
         game_over_q   <= 1'b0;
`ifdef PONG_SPEEDUP_EN
         hit_cnt_q     <= 4'd0;
         ball_speed_q  <= SPEED_INIT;
`endif
      end else begin
         vblank_dly_q <= vblank;
         case (state_q)
            ST_SERVE: begin
               ball_h_q <= H_CENTER;
               ball_v_q <= V_CENTER;
               if (tick_s) begin
                  if (serve_cnt_q == SERVE_LAST) begin
                     serve_cnt_q <= {SCW{1'b0}};
                     state_q     <= ST_PLAY;
                     serving_q   <= 1'b0;
                  end else begin
                     serve_cnt_q <= serve_cnt_q + SCW'(1);
                  end
               end
            end
            ST_PLAY: begin
               if (tick_s) begin
                  wait_cnt_q <= SETTLE_W;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == {WCW{1'b0}}) begin
                  state_q <= ST_EVAL;
               end else begin
                  wait_cnt_q <= wait_cnt_q - WCW'(1);
               end
            end
            ST_EVAL: begin
               if (coll_paddle) begin
                  // Paddle wins over wall: the ball is returned, not scored.
                  ball_dir_q  <= ~ball_dir_q;
                  ball_v_q    <= v_next_s;
                  ball_vdir_q <= vdir_next_s;
                  state_q     <= ST_PLAY;
`ifdef PONG_SPEEDUP_EN
                  if (hit_cnt_q == HIT_LAST) begin
                     hit_cnt_q <= 4'd0;
                     if (ball_speed_q < SPEED_MAX) begin
                        ball_speed_q <= ball_speed_q + 4'd1;
                     end else begin
                        ball_speed_q <= SPEED_MAX;
                     end
                  end else begin
                     hit_cnt_q <= hit_cnt_q + 4'd1;
                  end
`endif
               end else if (coll_wall) begin
                  // A ball travelling left got past the left player: right scores,
                  // and the next serve heads toward the player who conceded.
                  ball_h_q <= H_CENTER;
                  ball_v_q <= V_CENTER;
`ifdef PONG_SPEEDUP_EN
                  hit_cnt_q    <= 4'd0;
                  ball_speed_q <= SPEED_INIT;
`endif
                  if (ball_dir_q == `LEFT) begin
                     score_right_q <= score_right_q + 4'd1;
                     ball_dir_q    <= `LEFT;
                     if ((score_right_q + 4'd1) == WIN_SCORE) begin
                        state_q     <= ST_OVER;
                        game_over_q <= 1'b1;
                     end else begin
                        state_q   <= ST_SERVE;
                        serving_q <= 1'b1;
                     end
                  end else begin
                     score_left_q <= score_left_q + 4'd1;
                     ball_dir_q   <= `RIGHT;
                     if ((score_left_q + 4'd1) == WIN_SCORE) begin
                        state_q     <= ST_OVER;
                        game_over_q <= 1'b1;
                     end else begin
                        state_q   <= ST_SERVE;
                        serving_q <= 1'b1;
                     end
                  end
               end else begin
                  ball_h_q    <= h_next_s;
                  ball_v_q    <= v_next_s;
                  ball_vdir_q <= vdir_next_s;
                  state_q     <= ST_PLAY;
               end
            end
            ST_OVER: begin
               ball_h_q <= H_CENTER;
               ball_v_q <= V_CENTER;
               if (start) begin
                  score_left_q  <= 4'd0;
                  score_right_q <= 4'd0;
                  serve_cnt_q   <= {SCW{1'b0}};
                  state_q       <= ST_SERVE;
                  serving_q     <= 1'b1;
                  game_over_q   <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_SERVE;
               serving_q   <= 1'b1;
               game_over_q <= 1'b0;
            end
         endcase
      end
   end

   assign ball_h      = ball_h_q;
   assign ball_v      = ball_v_q;
   assign ball_dir    = ball_dir_q;
   assign ball_vdir   = ball_vdir_q;
   assign ball_speed  = speed_s;
   assign score_left  = score_left_q;
   assign score_right = score_right_q;
   assign serving     = serving_q;
   assign game_over   = game_over_q;

endmodule

// File: tb/tb_pong_ball_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pong_ball_sequencer
//
// Frame-level bench for pong_ball_sequencer. A behavioural model tracks the
// game one video frame at a time (serve countdown, ball motion with edge
// clamping, paddle/wall priority, scoring, optional speed ramp) and every
// DUT output is compared with it at the end of each frame.
// -----------------------------------------------------------------------------

`ifndef LEFT
`define LEFT 1'b0
`endif
`ifndef RIGHT
`define RIGHT 1'b1
`endif

module tb_pong_ball_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        vblank;
   logic        start;
   logic        coll_wall;
   logic        coll_paddle;
   logic [10:0] ball_h;
   logic [10:0] ball_v;
   logic        ball_dir;
   logic        ball_vdir;
   logic [3:0]  ball_speed;
   logic [3:0]  score_left;
   logic [3:0]  score_right;
   logic        serving;
   logic        game_over;

   int n_checks = 0;
   int n_fail   = 0;
   int frame_no = 0;

   // Frame-level model: mode 0 = serving, 1 = in play, 2 = game over.
   int m_mode, m_cnt, m_h, m_v, m_dir, m_vdir, m_spd, m_hits, m_sl, m_sr;

`ifdef PONG_SPEEDUP_EN
   localparam int SPEEDUP = 1;
`else
   localparam int SPEEDUP = 0;
`endif

   pong_ball_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .vblank      (vblank),
      .start       (start),
      .coll_wall   (coll_wall),
      .coll_paddle (coll_paddle),
      .ball_h      (ball_h),
      .ball_v      (ball_v),
      .ball_dir    (ball_dir),
      .ball_vdir   (ball_vdir),
      .ball_speed  (ball_speed),
      .score_left  (score_left),
      .score_right (score_right),
      .serving     (serving),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (frame %0d): got %0d, expected %0d", tag, frame_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0;
      m_h = 316; m_v = 236;
      m_dir = 1; m_vdir = 1;
      m_spd = 2; m_hits = 0;
      m_sl = 0; m_sr = 0;
   endtask

   // Ball must stay inside rows [8, 464]; reaching a limit flips direction.
   task automatic model_vert();
      if (m_vdir == 0) begin
         if (m_v - m_spd < 8) begin
            m_v = 8; m_vdir = 1;
         end else begin
            m_v = m_v - m_spd;
         end
      end else begin
         if (m_v + m_spd >= 464) begin
            m_v = 464; m_vdir = 0;
         end else begin
            m_v = m_v + m_spd;
         end
      end
   endtask

   task automatic model_frame(input bit w, input bit p);
      if (m_mode == 0) begin
         m_cnt++;
         if (m_cnt == 60) begin
            m_cnt = 0; m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (p) begin
            m_dir = 1 - m_dir;
            model_vert();
            if (SPEEDUP != 0) begin
               m_hits++;
               if (m_hits == 4) begin
                  m_hits = 0;
                  if (m_spd < 8) m_spd++;
               end
            end
         end else if (w) begin
            if (m_dir == 0) m_sr++;
            else m_sl++;
            m_spd = 2; m_hits = 0;
            m_h = 316; m_v = 236;
            m_mode = (m_sl == 9 || m_sr == 9) ? 2 : 0;
         end else begin
            m_h = (m_dir == 0) ? ((m_h - m_spd) & 'h7ff) : ((m_h + m_spd) & 'h7ff);
            model_vert();
         end
      end
   endtask

   task automatic compare_all();
      check_eq("ball_h",      32'(ball_h),      32'(m_h));
      check_eq("ball_v",      32'(ball_v),      32'(m_v));
      check_eq("ball_dir",    32'(ball_dir),    32'(m_dir));
      check_eq("ball_vdir",   32'(ball_vdir),   32'(m_vdir));
      check_eq("ball_speed",  32'(ball_speed),  32'(m_spd));
      check_eq("score_left",  32'(score_left),  32'(m_sl));
      check_eq("score_right", 32'(score_right), 32'(m_sr));
      check_eq("serving",     32'(serving),     32'(m_mode == 0));
      check_eq("game_over",   32'(game_over),   32'(m_mode == 2));
   endtask

   // One video frame: vblank high 8 cycles, low 2, collisions held throughout.
   task automatic run_frame(input bit w, input bit p);
      frame_no++;
      coll_wall = w; coll_paddle = p; vblank = 1'b1;
      repeat (8) @(negedge clk);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
      model_frame(w, p);
      compare_all();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      if (m_mode == 2) begin
         m_mode = 0; m_sl = 0; m_sr = 0; m_cnt = 0;
      end
      compare_all();
   endtask

   initial begin
      rst = 1'b1; vblank = 1'b0; start = 1'b0; coll_wall = 1'b0; coll_paddle = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;
      @(negedge clk);

      // Serve countdown, then the first in-play frame.
      for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0);
      check_eq("serve_exit_serving", 32'(serving), 32'd0);
      run_frame(1'b0, 1'b0);
      check_eq("first_move_h", 32'(ball_h), 32'd318);
      check_eq("first_move_v", 32'(ball_v), 32'd238);

      // Paddle and wall together: paddle takes priority.
      run_frame(1'b1, 1'b1);
      check_eq("both_coll_dir",   32'(ball_dir),    32'(`LEFT));
      check_eq("both_coll_h",     32'(ball_h),      32'd318);
      check_eq("both_coll_score", 32'(score_left + score_right), 32'd0);

      // Paddle hit train (the frame above already counted one hit).
      for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b1);
      check_eq("speed_after_4_hits", 32'(ball_speed), (SPEEDUP != 0) ? 32'd3 : 32'd2);
      for (int i = 0; i < 25; i++) run_frame(1'b0, 1'b1);
      check_eq("speed_saturated", 32'(ball_speed), (SPEEDUP != 0) ? 32'd8 : 32'd2);

      // Random play until someone wins, with stray start pulses that must be ignored.
      for (int i = 0; i < 4000 && m_mode != 2; i++) begin
         run_frame($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 31) == 0 && m_mode != 2) pulse_start();
      end
      check_eq("game_over_reached", 32'(game_over), 32'd1);
      check_eq("over_center_h", 32'(ball_h), 32'd316);
      check_eq("over_center_v", 32'(ball_v), 32'd236);
      run_frame(1'b1, 1'b0);
      pulse_start();
      check_eq("restart_serving", 32'(serving), 32'd1);
      check_eq("restart_scores",  32'(score_left + score_right), 32'd0);

      // Score one point, get back into play, then reset in the middle of WAIT.
      for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0);
      run_frame(1'b1, 1'b0);
      for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0);
      coll_wall = 1'b0; coll_paddle = 1'b0; vblank = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      // vblank is still high, so the first clock after release sees a new tick.
      repeat (5) @(negedge clk);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
      model_frame(1'b0, 1'b0);
      compare_all();
      run_frame(1'b1, 1'b0);
      check_eq("stale_wall_scores", 32'(score_left + score_right), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_ball_sequencer.md
# pong_ball_sequencer

Per-frame ball/game sequencer for the pong datapath. Once per video frame it waits for the collision detector's registered `coll_wall`/`coll_paddle` results, then applies the frame's ball update:

- moves the ball,
- bounces it off paddles and the top/bottom table edges,
- scores points and re-serves,
- ramps speed.

It owns `ball_h`, `ball_v`, `ball_dir` and `ball_speed` and feeds them back to the collision detector and the renderer.

## Interface
Parameters:
- `H_CENTER`, 11'd316, serve column of ball
- `V_CENTER`, 11'd236, serve row of ball
- `TABLE_TOP`, 11'd8, topmost legal `ball_v`
- `TABLE_BOTTOM`, 11'd472, first row below table
- `BALL_VSIZE`, 11'd8, ball height in rows
- `SETTLE`, 3, wait cycles after vblank rise before sampling collisions
- `SERVE_FRAMES`, 60, frames ball is parked before each serve
- `SPEED_INIT`, 4'd2, speed after reset/serve
- `SPEED_MAX`, 4'd8, speed ceiling
- `HITS_PER_STEP`, 4, paddle hits per speed increment
- `WIN_SCORE`, 4'd9, score that ends the game

Ports:
- `clk` in 1: system clock, same domain as `vblank`
- `rst` in 1: asynchronous, active-high reset
- `vblank` in 1: vertical blank level
- `start` in 1: one-cycle pulse; restarts the game from OVER
- `coll_wall` in 1: wall collision from the collision detector
- `coll_paddle` in 1: paddle collision from the collision detector
- `ball_h` out 11: ball column. Reset value `H_CENTER`.
- `ball_v` out 11: ball row. Reset value `V_CENTER`.
- `ball_dir` out 1: horizontal direction, encoded with `` `LEFT ``/`` `RIGHT `` from defs.v. Reset value `` `RIGHT ``.
- `ball_vdir` out 1: vertical direction, 0 = up, 1 = down. Reset value 1.
- `ball_speed` out 4: pixels per frame on each axis. Reset value `SPEED_INIT`.
- `score_left` out 4: left player score. Reset value 0.
- `score_right` out 4: right player score. Reset value 0.
- `serving` out 1: high in SERVE. Reset value 1.
- `game_over` out 1: high in OVER. Reset value 0.

## Operation
- Frame tick:
  - `vblank_d` is registered, reset value 0.
  - `tick = vblank & ~vblank_d`.
- SERVE (reset state):
  - Ball held at `H_CENTER`/`V_CENTER`.
  - Frame counter increments on each tick.
  - On the tick that makes the count equal `SERVE_FRAMES`: clear the counter and go to PLAY.
- PLAY: on a tick, load `wait_cnt = SETTLE` and go to WAIT.
- WAIT:
  - If `wait_cnt == 0`, go to EVAL; otherwise decrement.
  - Ticks are ignored in WAIT and EVAL.
- EVAL (one cycle) applies exactly one case, in priority order:
  1. `coll_paddle`: invert `ball_dir`; `ball_h` unchanged; increment hit counter (see Configuration). Vertical update applies. Go to PLAY.
  2. `coll_wall`:
     - Scorer is the right player if `` ball_dir == `LEFT ``, otherwise the left player; the scorer's score increments.
     - Set `ball_dir` toward the conceding player.
     - Set `ball_speed = SPEED_INIT` and clear the hit counter.
     - Recenter the ball.
     - If the new score equals `WIN_SCORE`, go to OVER; otherwise go to SERVE.
  3. Neither: `ball_h` ± `ball_speed` (− when `` `LEFT ``). Vertical update applies. Go to PLAY.
- Vertical update, all comparisons in 12 bits to avoid wrap:
  - Up: if `ball_v < TABLE_TOP + ball_speed`, set `ball_v = TABLE_TOP` and `ball_vdir = 1`; else `ball_v -= ball_speed`.
  - Down: if `ball_v + BALL_VSIZE + ball_speed >= TABLE_BOTTOM`, set `ball_v = TABLE_BOTTOM - BALL_VSIZE` and `ball_vdir = 0`; else `ball_v += ball_speed`.
- OVER:
  - Ball held at center; scores frozen.
  - A `start` pulse clears both scores and the serve counter, then goes to SERVE.
  - `start` is ignored in all other states.

## Timing
- Let E0 be the clock edge at which `tick` is high in PLAY.
- Edges E1 through E_SETTLE count down `wait_cnt`.
- Edge E(SETTLE+1) enters EVAL.
- Edge E(SETTLE+2) registers new ball outputs, scores and state. All outputs are registered.
- `SETTLE` must cover the collision detector's posedge-vblank register plus 2-flop margin. Minimum 2.
- Asynchronous `rst` mid-frame: every register returns to its reset value immediately, including `vblank_d`, the counters and the hit count. The FSM restarts in SERVE.
- `serving` and `game_over` are decoded from registered state, glitch-free.

## Configuration
- Macro: `PONG_SPEEDUP_EN`.
- Defined:
  - A 4-bit hit counter counts paddle hits.
  - On the hit that brings the count to `HITS_PER_STEP`, the counter clears and `ball_speed` increments, saturating at `SPEED_MAX`.
  - The speed change takes effect from the next frame's motion.
- Undefined:
  - No hit counter is instantiated.
  - `ball_speed` is constant at `SPEED_INIT` at all times.

## Test plan
- Reset then 60 ticks: `serving` = 1 through tick 59; after tick 60, `serving` = 0 and the next frame's EVAL sets `ball_h` = 318, `ball_v` = 238.
- Ball moving down at `ball_v` = 463, speed 2, no collisions: EVAL gives `ball_v` = 464, `ball_vdir` = 0. Top case, up at `ball_v` = 9: gives 8, `ball_vdir` = 1.
- `coll_paddle` and `coll_wall` both high while `` ball_dir == `RIGHT ``: `ball_dir` becomes `` `LEFT ``, `ball_h` unchanged, scores unchanged.
- `coll_wall` while moving `` `LEFT `` with `score_right` = 8: `score_right` = 9, `game_over` = 1, ball at 316/236. A `start` pulse then gives scores 0/0 and `serving` = 1.
- With `PONG_SPEEDUP_EN`: 4 paddle hits take speed from 2 to 3; 28 hits take it to 8 and it saturates. Without the macro, speed stays 2.
- Assert `rst` during WAIT: all outputs return to reset values the same cycle; a stale `coll_wall` afterwards produces no score change.
